// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt controller in front of the CPU
// interrupt_request input. Per-source enable, edge/level mode, latched
// pending bits and a fixed-priority vector register (index 0 wins).
//
// Register window (addr = mem_addr[3:2]):
//   0 PENDING  read pending view; write-1-to-clear latched (edge) bits
//   1 ENABLE   read/write
//   2 MODE     read/write, 1 = rising-edge latched, 0 = level (live)
//   3 VECTOR   read {valid, 26'b0, idx}; write acks source data_in[4:0]
//
// Optional build macro IRQ_CONTROLLER_SYNC_EN: adds a 2-flop synchronizer
// on every src bit (for asynchronous sources), one extra clk of latency.
//
// irq is registered from the next-state pending/enable view, so after every
// edge irq == |(pending & enable) as seen through the register window.
module irq_controller #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         resetq,
  input  logic         select,
  input  logic [3:0]   wr,
  input  logic [1:0]   addr,
  input  logic [31:0]  data_in,
  output logic [31:0]  data_out,
  input  logic [N-1:0] src,
  output logic         irq
);

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_ENABLE  = 2'd1;
  localparam logic [1:0] A_MODE    = 2'd2;
  localparam logic [1:0] A_VECTOR  = 2'd3;

  logic [N-1:0] s_q, s_d, prev_q;
  logic [N-1:0] latched_q, latched_d;
  logic [N-1:0] enable_q, enable_d;
  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] clr, rise;
  logic [N-1:0] pend_view, pend_view_d, active;
  logic [31:0]  wmask32, wdata32;
  logic         wr_en;
  logic [4:0]   vec_idx;
  logic         vec_valid;
  logic         unused_wr_bits;

`ifdef IRQ_CONTROLLER_SYNC_EN
  logic [N-1:0] sync1_q;

  // First synchronizer stage; s_q acts as the second stage.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) sync1_q <= '0;
    else         sync1_q <= src;
  end

  assign s_d = sync1_q;
`else
  assign s_d = src;
`endif

  // Source sample and its previous value for rising-edge detection.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s_q    <= '0;
      prev_q <= '0;
    end else begin
      s_q    <= s_d;
      prev_q <= s_q;
    end
  end

  assign wr_en   = select && (wr != 4'b0000);
  assign wmask32 = {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};
  assign wdata32 = data_in & wmask32;
  // Lanes above N are deliberately dropped.
  assign unused_wr_bits = ^{wdata32, wmask32};

  // Register write decode: byte-lane merges for ENABLE/MODE, clear masks
  // for PENDING W1C and VECTOR ack (the ack index lives in byte lane 0).
  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    clr      = '0;
    if (wr_en) begin
      case (addr)
        A_PENDING: clr = wdata32[N-1:0];
        A_ENABLE:  enable_d = (enable_q & ~wmask32[N-1:0]) | wdata32[N-1:0];
        A_MODE:    mode_d   = (mode_q   & ~wmask32[N-1:0]) | wdata32[N-1:0];
        default: begin
          if (wr[0]) begin
            for (int i = 0; i < N; i++) begin
              if (data_in[4:0] == 5'(i)) clr[i] = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rise = s_q & ~prev_q;

  // Latched bits exist only while a source stays in edge mode across the
  // edge: leaving edge mode discards it, entering starts from 0. A rise
  // beats a concurrent clear.
  assign latched_d = mode_q & mode_d & (rise | (latched_q & ~clr));

  assign pend_view   = (mode_q & latched_q) | (~mode_q & s_q);
  assign pend_view_d = (mode_d & latched_d) | (~mode_d & s_d);
  assign active      = pend_view & enable_q;

  // Control registers and the registered interrupt request.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      latched_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      irq       <= 1'b0;
    end else begin
      latched_q <= latched_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq       <= |(pend_view_d & enable_d);
    end
  end

  // Fixed priority: lowest active index wins; idx reads 0 when none active.
  always_comb begin
    vec_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 5'(i);
    end
  end

  assign vec_valid = |active;

  function automatic logic [31:0] zext(input logic [N-1:0] v);
    zext         = '0;
    zext[N-1:0]  = v;
  endfunction

  // Combinational register read mux, no side effects.
  always_comb begin
    data_out = '0;
    case (addr)
      A_PENDING: data_out = zext(pend_view);
      A_ENABLE:  data_out = zext(enable_q);
      A_MODE:    data_out = zext(mode_q);
      A_VECTOR:  data_out = {vec_valid, 26'b0, vec_idx};
      default:   data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller: an N=8 instance driven from a vector table
// plus hand-written multi-cycle sequences, and an N=32 instance for the
// byte-lane / high-index masking case.
module tb_irq_controller;

`ifdef IRQ_CONTROLLER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_EN   = 2'd1;
  localparam logic [1:0] A_MODE = 2'd2;
  localparam logic [1:0] A_VEC  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  // N = 8 instance
  logic        select = 1'b0;
  logic [3:0]  wr = 4'h0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [7:0]  src = 8'h00;
  logic        irq;

  // N = 32 instance
  logic        sel32 = 1'b0;
  logic [3:0]  wr32 = 4'h0;
  logic [1:0]  addr32 = 2'd0;
  logic [31:0] din32 = '0;
  logic [31:0] dout32;
  logic [31:0] src32 = '0;
  logic        irq32;

  irq_controller #(.N(8)) dut (
    .clk(clk), .resetq(resetq), .select(select), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .src(src), .irq(irq)
  );

  irq_controller #(.N(32)) dut32 (
    .clk(clk), .resetq(resetq), .select(sel32), .wr(wr32), .addr(addr32),
    .data_in(din32), .data_out(dout32), .src(src32), .irq(irq32)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $display("FAIL %s: got %h, no expected value queued", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_miss++;
        $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
    select  = 1'b1;
    addr    = a;
    wr      = m;
    data_in = d;
    tick(1);
    select  = 1'b0;
    wr      = 4'h0;
  endtask

  task automatic reg_read(input string name, input logic [1:0] a);
    addr = a;
    #1;
    check(name, data_out);
  endtask

  task automatic reg_write32(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
    sel32  = 1'b1;
    addr32 = a;
    wr32   = m;
    din32  = d;
    tick(1);
    sel32  = 1'b0;
    wr32   = 4'h0;
  endtask

  task automatic reg_read32(input string name, input logic [1:0] a);
    addr32 = a;
    #1;
    check(name, dout32);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [3:0]  wm;
    logic [31:0] wd;
    logic [7:0]  sv;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // we  wa      wm    wd             src    ra      rd              irq
    tbl[0]  = '{1'b1, A_EN,   4'hF, 32'h0000_0012, 8'hFF, A_EN,   32'h0000_0012, 1'b1};
    tbl[1]  = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'hFF, A_VEC,  32'h8000_0001, 1'b1};
    tbl[2]  = '{1'b1, A_EN,   4'h2, 32'hFFFF_FFFF, 8'hFF, A_EN,   32'h0000_0012, 1'b1};
    tbl[3]  = '{1'b1, A_EN,   4'h1, 32'hFFFF_FF00, 8'hFF, A_EN,   32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, A_EN,   4'h1, 32'h0000_0080, 8'h80, A_VEC,  32'h8000_0007, 1'b1};
    tbl[5]  = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'h00, A_VEC,  32'h0000_0000, 1'b0};
    tbl[6]  = '{1'b1, A_PEND, 4'hF, 32'h0000_00FF, 8'h80, A_PEND, 32'h0000_0080, 1'b1};
    tbl[7]  = '{1'b1, A_MODE, 4'hF, 32'hFFFF_FFFF, 8'h80, A_MODE, 32'h0000_00FF, 1'b0};
    tbl[8]  = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'h80, A_PEND, 32'h0000_0000, 1'b0};
    tbl[9]  = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'h00, A_PEND, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'h81, A_PEND, 32'h0000_0081, 1'b1};
    tbl[11] = '{1'b0, A_EN,   4'h0, 32'h0000_0000, 8'h00, A_VEC,  32'h8000_0007, 1'b1};
    tbl[12] = '{1'b1, A_VEC,  4'hF, 32'h0000_0008, 8'h00, A_PEND, 32'h0000_0081, 1'b1};
    tbl[13] = '{1'b1, A_PEND, 4'hF, 32'h0000_0080, 8'h00, A_PEND, 32'h0000_0001, 1'b0};
    tbl[14] = '{1'b1, A_MODE, 4'hF, 32'h0000_00FE, 8'h00, A_PEND, 32'h0000_0000, 1'b0};
    tbl[15] = '{1'b1, A_MODE, 4'h2, 32'h0000_0000, 8'h00, A_MODE, 32'h0000_00FE, 1'b0};

    // ---- reset held with all sources high ----
    src = 8'hFF;
    tick(3);
    expect_val(32'd0);
    check("reset_irq", {31'd0, irq});
    for (int a = 0; a < 4; a++) begin
      expect_val(32'd0);
      reg_read($sformatf("reset_reg%0d", a), 2'(a));
    end
    @(negedge clk);
    resetq = 1'b1;
    tick(LAT + 1);
    expect_val(32'h0000_00FF);
    reg_read("post_reset_pending", A_PEND);
    expect_val(32'd0);
    check("post_reset_irq", {31'd0, irq});

    // ---- table-driven vectors ----
    for (int v = 0; v < 16; v++) begin
      src = tbl[v].sv;
      expect_val(tbl[v].exp_rd);
      expect_val({31'd0, tbl[v].exp_irq});
      if (tbl[v].we) begin
        reg_write(tbl[v].wa, tbl[v].wm, tbl[v].wd);
        tick(2);
      end else begin
        tick(3);
      end
      reg_read($sformatf("tbl%0d_rd", v), tbl[v].ra);
      check($sformatf("tbl%0d_irq", v), {31'd0, irq});
    end

    // ---- edge latch, latency and VECTOR ack ----
    reg_write(A_MODE, 4'hF, 32'h04);
    reg_write(A_EN, 4'hF, 32'h04);
    src = 8'h00;
    tick(3);
    src = 8'h04;
    for (int c = 1; c <= LAT; c++) begin
      expect_val({31'd0, (c == LAT)});
      tick(1);
      src = 8'h00;
      check($sformatf("edge_irq_c%0d", c), {31'd0, irq});
    end
    expect_val(32'h0000_0004);
    reg_read("edge_pending", A_PEND);
    expect_val(32'h8000_0002);
    reg_read("edge_vector", A_VEC);
    reg_write(A_VEC, 4'hF, 32'h2);
    expect_val(32'd0);
    reg_read("edge_ack_pending", A_PEND);
    expect_val(32'd0);
    check("edge_ack_irq", {31'd0, irq});

    // ---- priority between simultaneous rises ----
    reg_write(A_MODE, 4'hF, 32'hFF);
    reg_write(A_EN, 4'hF, 32'hFF);
    src = 8'h22;
    tick(LAT);
    expect_val(32'h8000_0001);
    reg_read("prio_first", A_VEC);
    reg_write(A_VEC, 4'hF, 32'h1);
    expect_val(32'h8000_0005);
    reg_read("prio_second", A_VEC);
    reg_write(A_VEC, 4'hF, 32'h5);
    expect_val(32'h0000_0000);
    reg_read("prio_none", A_VEC);
    expect_val(32'd0);
    check("prio_irq", {31'd0, irq});

    // ---- rise concurrent with W1C: set wins ----
    reg_write(A_EN, 4'hF, 32'h00);
    src = 8'h00;
    tick(3);
    src = 8'h08;
    tick(3);
    src = 8'h00;
    tick(3);
    src = 8'h08;
    tick(LAT - 1);
    reg_write(A_PEND, 4'hF, 32'h08);
    expect_val(32'h0000_0008);
    reg_read("setclr_pending", A_PEND);
    reg_write(A_PEND, 4'hF, 32'h08);
    expect_val(32'h0000_0000);
    reg_read("setclr_later_clear", A_PEND);

    // ---- level mode ignores W1C ----
    reg_write(A_MODE, 4'hF, 32'h00);
    reg_write(A_EN, 4'hF, 32'h10);
    src = 8'h10;
    tick(LAT);
    reg_write(A_PEND, 4'hF, 32'h10);
    expect_val(32'h0000_0010);
    reg_read("level_pending", A_PEND);
    expect_val(32'd1);
    check("level_irq_high", {31'd0, irq});
    src = 8'h00;
    tick(LAT);
    expect_val(32'd0);
    check("level_irq_low", {31'd0, irq});

    // ---- N=32 byte lanes and masking ----
    reg_write32(A_EN, 4'b0010, 32'hFFFF_FFFF);
    expect_val(32'h0000_FF00);
    reg_read32("n32_enable_lane1", A_EN);
    reg_write32(A_MODE, 4'hF, 32'hFFFF_FFFF);
    src32 = 32'h0010_0000;
    tick(3);
    expect_val(32'h0010_0000);
    reg_read32("n32_pending", A_PEND);
    expect_val(32'd0);
    check("n32_irq_masked", {31'd0, irq32});
    reg_write32(A_EN, 4'b0100, 32'h0010_0000);
    expect_val(32'd1);
    check("n32_irq_enabled", {31'd0, irq32});
    expect_val(32'h8000_0014);
    reg_read32("n32_vector", A_VEC);

    // ---- disable retains pending, then mid-operation reset ----
    reg_write(A_MODE, 4'hF, 32'hFF);
    reg_write(A_EN, 4'hF, 32'hFF);
    src = 8'h01;
    tick(3);
    expect_val(32'd1);
    check("pre_reset_irq", {31'd0, irq});
    reg_write(A_EN, 4'hF, 32'h00);
    expect_val(32'd0);
    check("disable_irq", {31'd0, irq});
    expect_val(32'h0000_0001);
    reg_read("disable_pending_kept", A_PEND);
    reg_write(A_EN, 4'hF, 32'h01);
    expect_val(32'd1);
    check("reenable_irq", {31'd0, irq});
    #2;
    resetq = 1'b0;
    #1;
    expect_val(32'd0);
    check("midreset_irq", {31'd0, irq});
    for (int a = 0; a < 4; a++) begin
      expect_val(32'd0);
      reg_read($sformatf("midreset_reg%0d", a), 2'(a));
    end
    expect_val(32'd0);
    check("midreset_irq32", {31'd0, irq32});

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
